avalon_sdram_responder: RTL and testbench

- Avalon-MM slave (responder) modelling the HPS SDRAM port: 64-bit data, 29-bit word address, bursts, byte enables, pipelined reads with fixed latency.
- Backed by an internal 64-bit word array.
- Sits where the SDRAM bridge normally sits, so fabric masters can be brought up and regressed in simulation and on-chip without the HPS.
- Provides debug words in the same format as other fabric blocks.

---
 rtl/avalon_sdram_responder.sv | 173 +++++++++++++++++
 tb/tb_avalon_sdram_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_sdram_responder.sv
// Avalon-MM responder standing in for the HPS SDRAM port: 64-bit words, bursts, byte enables, fixed read latency.
// Define AVALON_RESPONDER_WAIT_INJECT_EN to hold off every new IDLE command with one waitrequest cycle.
module avalon_sdram_responder #(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [28:0] address,
    input  logic [7:0]  burstcount,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] writedata,
    input  logic [7:0]  byteenable,
    output logic        waitrequest,
    output logic [63:0] readdata,
    output logic        readdatavalid,
    output logic [31:0] debug_value0,
    output logic [31:0] debug_value1
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WBURST = 3'd2,
        ST_RLAT   = 3'd3,
        ST_RBURST = 3'd4
    } state_t;

`ifdef AVALON_RESPONDER_WAIT_INJECT_EN
    localparam bit WAIT_INJECT = 1'b1;
`else
    localparam bit WAIT_INJECT = 1'b0;
`endif

    localparam int unsigned          DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0]           LAT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
    localparam logic [ADDR_BITS-1:0] IDX_ONE  = ADDR_BITS'(1);

    logic [63:0] mem [DEPTH];

    state_t               state, state_n;
    logic [ADDR_BITS-1:0] idx, idx_n, mem_addr, addr_idx;
    logic [7:0]           rem, rem_n, err, err_n, n_beats;
    logic [3:0]           lat, lat_n;
    logic                 stall, stall_n;
    logic                 rdv_n, mem_we;
    logic [63:0]          rdata_n;
    logic [15:0]          idx16;
    logic                 unused_addr_hi;

    assign addr_idx       = address[ADDR_BITS-1:0];
    assign unused_addr_hi = ^address[28:ADDR_BITS];
    assign n_beats        = (burstcount == 8'd0) ? 8'd1 : burstcount;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decoded from registered state only, so no input reaches waitrequest combinationally.
    always_comb begin
        waitrequest = 1'b1;
        case (state)
            ST_IDLE:   waitrequest = WAIT_INJECT ? ~stall : 1'b0;
            ST_WBURST: waitrequest = 1'b0;
            default:   waitrequest = 1'b1;
        endcase
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        rem_n    = rem;
        lat_n    = lat;
        err_n    = err;
        stall_n  = 1'b0;
        rdv_n    = 1'b0;
        rdata_n  = readdata;
        mem_we   = 1'b0;
        mem_addr = idx;
        case (state)
            ST_INIT: state_n = ST_IDLE;
            ST_IDLE: begin
                if (WAIT_INJECT && !stall) stall_n = read | write;
                if (!waitrequest && (read || write)) begin
                    idx_n = addr_idx;
                    if (write) begin
                        mem_we   = 1'b1;
                        mem_addr = addr_idx;
                        if (read) err_n = sat_inc(err);
                        if (n_beats > 8'd1) begin
                            rem_n   = n_beats - 8'd1;
                            state_n = ST_WBURST;
                        end else begin
                            rem_n = 8'd0;
                        end
                    end else begin
                        rem_n = n_beats;
                        if (READ_LATENCY > 1) begin
                            lat_n   = LAT_INIT;
                            state_n = ST_RLAT;
                        end else begin
                            state_n = ST_RBURST;
                        end
                    end
                end
            end
            ST_WBURST: begin
                if (read) err_n = sat_inc(err);
                if (write) begin
                    mem_we   = 1'b1;
                    mem_addr = idx + IDX_ONE;
                    idx_n    = idx + IDX_ONE;
                    rem_n    = rem - 8'd1;
                    if (rem == 8'd1) state_n = ST_IDLE;
                end
            end
            ST_RLAT: begin
                if (lat == 4'd0) state_n = ST_RBURST;
                else             lat_n   = lat - 4'd1;
            end
            ST_RBURST: begin
                // Extra edge with rem==0 drops readdatavalid and waitrequest together.
                if (rem != 8'd0) begin
                    rdv_n   = 1'b1;
                    rdata_n = mem[idx];
                    idx_n   = idx + IDX_ONE;
                    rem_n   = rem - 8'd1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_INIT;
            idx           <= '0;
            rem           <= '0;
            lat           <= '0;
            err           <= '0;
            stall         <= 1'b0;
            readdatavalid <= 1'b0;
            readdata      <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            rem           <= rem_n;
            lat           <= lat_n;
            err           <= err_n;
            stall         <= stall_n;
            readdatavalid <= rdv_n;
            readdata      <= rdata_n;
        end
    end

    // Memory deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (byteenable[b]) mem[mem_addr][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    assign idx16        = 16'(idx);
    assign debug_value0 = {3'b0, waitrequest, 3'b0, readdatavalid, 3'b0, read, 3'b0, write,
                           4'b0, err, 1'b0, state};
    assign debug_value1 = {rem, 8'b0, idx16};

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Directed self-checking bench for avalon_sdram_responder (default parameters; honours AVALON_RESPONDER_WAIT_INJECT_EN).
module tb_avalon_sdram_responder;

    localparam int L = 2;
`ifdef AVALON_RESPONDER_WAIT_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        read, write;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [31:0] debug_value0, debug_value1;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_beats [16];

    avalon_sdram_responder #(.ADDR_BITS(10), .READ_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .address(address), .burstcount(burstcount),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .debug_value0(debug_value0), .debug_value1(debug_value1)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        string       name;
    } vec_t;

    vec_t tbl [12];

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_accept(output bit ok);
        bit w;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            w = waitrequest;
            tick();
            if (!w) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be,
                            input bit rd_too, input string name);
        bit ok;
        address = a; writedata = d; byteenable = be; burstcount = 8'd1;
        write = 1'b1; read = rd_too;
        wait_accept(ok);
        write = 1'b0; read = 1'b0;
        check64({name, "_accept"}, 64'(ok), 64'd1);
    endtask

    task automatic read_burst(input logic [28:0] a, input int n, input string name);
        bit ok, pattern_ok, exp_v;
        address = a; burstcount = 8'(n); read = 1'b1;
        wait_accept(ok);
        read = 1'b0;
        check64({name, "_accept"}, 64'(ok), 64'd1);
        if (!ok) return;
        pattern_ok = 1'b1;
        for (int j = 1; j <= L + n; j++) begin
            tick();
            exp_v = (j >= L) && (j < L + n);
            if (readdatavalid !== exp_v) pattern_ok = 1'b0;
            if (exp_v && readdatavalid === 1'b1)
                check64($sformatf("%s_beat%0d", name, j - L), readdata, exp_beats[j - L]);
        end
        check64({name, "_rdv_pattern"}, 64'(pattern_ok), 64'd1);
        check64({name, "_wait_release"}, 64'(waitrequest), 64'(INJ));
    endtask

    initial begin
        bit ok;
        int rdv_seen;

        tbl[0]  = '{1'b1, 29'h0600_0000, 64'hDEAD_BEEF_CAFE_BABE, 8'hFF, "t1_write"};
        tbl[1]  = '{1'b0, 29'h0600_0000, 64'hDEAD_BEEF_CAFE_BABE, 8'h00, "t1_read"};
        tbl[2]  = '{1'b1, 29'h0000_0005, 64'h2357_1113_1719_2329, 8'hFF, "t2_preload"};
        tbl[3]  = '{1'b1, 29'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, "t2_partial"};
        tbl[4]  = '{1'b0, 29'h0000_0005, 64'h2357_1113_FFFF_FFFF, 8'h00, "t2_read"};
        tbl[5]  = '{1'b0, 29'h0000_0000, 64'hDEAD_BEEF_CAFE_BABE, 8'h00, "alias_read"};
        tbl[6]  = '{1'b1, 29'h0000_0005, 64'h0000_0000_0000_0000, 8'hF0, "be_hi_write"};
        tbl[7]  = '{1'b0, 29'h0000_0005, 64'h0000_0000_FFFF_FFFF, 8'h00, "be_hi_read"};
        tbl[8]  = '{1'b1, 29'h0000_0005, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, "be_none_write"};
        tbl[9]  = '{1'b0, 29'h0000_0005, 64'h0000_0000_FFFF_FFFF, 8'h00, "be_none_read"};
        tbl[10] = '{1'b1, 29'h1FFF_FFFF, 64'h1111_2222_3333_4444, 8'hFF, "top_write"};
        tbl[11] = '{1'b0, 29'h0000_03FF, 64'h1111_2222_3333_4444, 8'h00, "top_read"};

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; burstcount = 8'd1;
        writedata = '0; byteenable = '0;

        repeat (2) tick();
        check64("rst_wait", 64'(waitrequest), 64'd1);
        check64("rst_rdv", 64'(readdatavalid), 64'd0);
        check64("rst_rdata", readdata, 64'd0);
        check64("rst_state", 64'(debug_value0[3:0]), 64'd0);
        reset = 1'b0;
        check64("init_wait", 64'(waitrequest), 64'd1);
        tick();
        check64("idle_state", 64'(debug_value0[3:0]), 64'd1);
        check64("idle_wait", 64'(waitrequest), 64'(INJ));
        check64("idle_errcnt", 64'(debug_value0[11:4]), 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].be, 1'b0, tbl[i].name);
            end else begin
                exp_beats[0] = tbl[i].data;
                read_burst(tbl[i].addr, 1, tbl[i].name);
            end
        end

        // Simultaneous read+write: write lands, read dropped, error counted.
        do_write(29'd9, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, "t4_rw");
        rdv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (readdatavalid === 1'b1) rdv_seen++;
            tick();
        end
        check64("t4_no_rdv", 64'(rdv_seen), 64'd0);
        check64("t4_errcnt", 64'(debug_value0[11:4]), 64'd1);
        exp_beats[0] = 64'h0123_4567_89AB_CDEF;
        read_burst(29'd9, 1, "t4_read");

        // Read asserted during a write burst beat is also an error.
        address = 29'd20; burstcount = 8'd2; writedata = 64'hA5A5; byteenable = 8'hFF; write = 1'b1;
        wait_accept(ok);
        check64("t4b_accept", 64'(ok), 64'd1);
        writedata = 64'h5A5A; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        check64("t4b_errcnt", 64'(debug_value0[11:4]), 64'd2);
        exp_beats[0] = 64'hA5A5; exp_beats[1] = 64'h5A5A;
        read_burst(29'd20, 2, "t4b_read");

        // Reset during beat 2 of an 8-beat read.
        address = 29'h0600_0000; burstcount = 8'd8; read = 1'b1;
        wait_accept(ok);
        read = 1'b0;
        check64("t5_accept", 64'(ok), 64'd1);
        tick();
        check64("t5_lat_rdv", 64'(readdatavalid), 64'd0);
        tick();
        check64("t5_beat0", readdata, 64'hDEAD_BEEF_CAFE_BABE);
        tick();
        check64("t5_beat1_rdv", 64'(readdatavalid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check64("t5_async_rdv", 64'(readdatavalid), 64'd0);
        check64("t5_async_wait", 64'(waitrequest), 64'd1);
        check64("t5_async_rdata", readdata, 64'd0);
        tick();
        reset = 1'b0;
        check64("t5_init_wait", 64'(waitrequest), 64'd1);
        check64("t5_init_rdv", 64'(readdatavalid), 64'd0);
        tick();
        check64("t5_idle_state", 64'(debug_value0[3:0]), 64'd1);
        check64("t5_errcnt_cleared", 64'(debug_value0[11:4]), 64'd0);
        exp_beats[0] = 64'hDEAD_BEEF_CAFE_BABE;
        read_burst(29'h0600_0000, 1, "t5_mem_kept");

        // 4-beat wrapping write with a master stall after beat 2.
        address = 29'd1022; burstcount = 8'd4; writedata = 64'd1; byteenable = 8'hFF; write = 1'b1;
        wait_accept(ok);
        check64("t3_accept", 64'(ok), 64'd1);
        check64("t3_burst_wait", 64'(waitrequest), 64'd0);
        writedata = 64'd2;
        tick();
        write = 1'b0;
        tick();
        check64("t3_stall_dbg1", 64'(debug_value1), 64'h0200_03FF);
        write = 1'b1; writedata = 64'd3;
        tick();
        writedata = 64'd4;
        tick();
        write = 1'b0;
        check64("t3_back_idle", 64'(debug_value0[3:0]), 64'd1);
        exp_beats[0] = 64'd1; exp_beats[1] = 64'd2; exp_beats[2] = 64'd3; exp_beats[3] = 64'd4;
        read_burst(29'd1022, 4, "t3_read");
        exp_beats[0] = 64'd3;
        read_burst(29'd0, 1, "t3_idx0");
        exp_beats[0] = 64'd4;
        read_burst(29'd1, 1, "t3_idx1");

        // Wait injection: one stall cycle, then fixed latency from acceptance.
        address = 29'd0; burstcount = 8'd1; read = 1'b1;
`ifdef AVALON_RESPONDER_WAIT_INJECT_EN
        check64("t6_stall_first", 64'(waitrequest), 64'd1);
        tick();
        check64("t6_release", 64'(waitrequest), 64'd0);
`else
        check64("t6_zero_wait", 64'(waitrequest), 64'd0);
`endif
        tick();
        read = 1'b0;
        check64("t6_accepted_wait", 64'(waitrequest), 64'd1);
        check64("t6_acc_rdv", 64'(readdatavalid), 64'd0);
        tick();
        check64("t6_lat_rdv", 64'(readdatavalid), 64'd0);
        tick();
        check64("t6_first_rdv", 64'(readdatavalid), 64'd1);
        check64("t6_first_data", readdata, 64'd3);
        tick();
        check64("t6_end_rdv", 64'(readdatavalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
